// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the byte-lane count.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Four byte lanes; the lane logic is written for a 32-bit bus only.
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage : lsu_pkg

// File: rtl/lsu_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
//
// Handshake: the master raises mem_valid with stable mem_we/mem_be/mem_addr/
// mem_wdata and holds every field unchanged until the slave answers with
// mem_ready; the transfer completes in the cycle where mem_valid and
// mem_ready are both high, and mem_rdata is only meaningful in that cycle
// for reads (mem_we=0).
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int BUS_WIDTH = 32
);

  logic                 mem_valid;
  logic                 mem_we;
  logic [BE_W-1:0]      mem_be;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;
  logic                 mem_ready;
  logic [BUS_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_be,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_be,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );

endinterface : lsu_if

// File: rtl/lsu_lane_format.sv
// Byte-lane steering for the load/store unit: store byte enables and data
// replication, alignment check, and load lane extraction with extension.
module lsu_lane_format
  import lsu_pkg::*;
(
  // store / request side
  input  logic [1:0]      i_st_size,
  input  logic [1:0]      i_st_off,
  input  logic [31:0]     i_st_data,
  output logic            o_aligned,
  output logic [BE_W-1:0] o_st_be,
  output logic [31:0]     o_st_wdata,
  // load side
  input  logic [1:0]      i_ld_size,
  input  logic [1:0]      i_ld_off,
  input  logic            i_ld_unsigned,
  input  logic [31:0]     i_ld_rdata,
  output logic [31:0]     o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_ld_sign;

  always_comb begin
    o_aligned  = 1'b0;
    o_st_be    = '0;
    o_st_wdata = '0;
    case (i_st_size)
      SIZE_BYTE: begin
        o_aligned  = 1'b1;
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SIZE_HALF: begin
        o_aligned  = ~i_st_off[0];
        o_st_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      SIZE_WORD: begin
        o_aligned  = (i_st_off == 2'b00);
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
      end
      default: begin
        // Size 11 is illegal: never aligned, so nothing is issued.
        o_aligned  = 1'b0;
        o_st_be    = '0;
        o_st_wdata = '0;
      end
    endcase
  end

  always_comb begin
    w_ld_byte = i_ld_rdata[{i_ld_off, 3'b000} +: 8];
    w_ld_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    w_ld_sign = 1'b0;
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SIZE_BYTE: begin
        w_ld_sign = ~i_ld_unsigned & w_ld_byte[7];
        o_ld_data = {{24{w_ld_sign}}, w_ld_byte};
      end
      SIZE_HALF: begin
        w_ld_sign = ~i_ld_unsigned & w_ld_half[15];
        o_ld_data = {{16{w_ld_sign}}, w_ld_half};
      end
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule : lsu_lane_format

// File: rtl/load_store_unit.sv
// Data-memory access stage: takes the ALU result as effective address, runs
// one valid/ready memory transaction per load/store and stalls the core.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BUS_WIDTH = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BUS_WIDTH-1:0] alu_result,
  input  logic [BUS_WIDTH-1:0] store_data,
  output logic                 stall,
  output logic                 misaligned,
  output logic                 load_valid,
  output logic [BUS_WIDTH-1:0] load_data,
  output lsu_state_e           dbg_state,
  lsu_if.master                mem
);

  lsu_state_e r_state;
  lsu_state_e w_next_state;

  logic                 r_mem_we;
  logic [BE_W-1:0]      r_mem_be;
  logic [BUS_WIDTH-1:0] r_mem_addr;
  logic [BUS_WIDTH-1:0] r_mem_wdata;
  logic [1:0]           r_size;
  logic [1:0]           r_off;
  logic                 r_unsigned;
  logic [BUS_WIDTH-1:0] r_load_data;

  logic                 w_aligned;
  logic [BE_W-1:0]      w_st_be;
  logic [BUS_WIDTH-1:0] w_st_wdata;
  logic [BUS_WIDTH-1:0] w_ld_data;
  logic                 w_accept;
  logic                 w_complete;

  lsu_lane_format u_lane (
    .i_st_size     (req_size),
    .i_st_off      (alu_result[1:0]),
    .i_st_data     (store_data),
    .o_aligned     (w_aligned),
    .o_st_be       (w_st_be),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (mem.mem_rdata),
    .o_ld_data     (w_ld_data)
  );

  assign w_accept   = (r_state == ST_IDLE) && req_valid && w_aligned;
  assign w_complete = (r_state == ST_BUSY) && mem.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    misaligned   = 1'b0;
    load_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Faulting requests are flagged and dropped without stalling.
        misaligned = req_valid && !w_aligned;
        stall      = w_accept;
        if (w_accept) begin
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        load_valid   = !r_mem_we;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured once at accept so they stay stable in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_size      <= SIZE_BYTE;
      r_off       <= 2'b00;
      r_unsigned  <= 1'b0;
    end else if (w_accept) begin
      r_mem_we    <= req_we;
      r_mem_be    <= w_st_be;
      r_mem_addr  <= {alu_result[BUS_WIDTH-1:2], 2'b00};
      r_mem_wdata <= w_st_wdata;
      r_size      <= req_size;
      r_off       <= alu_result[1:0];
      r_unsigned  <= req_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_data <= '0;
    end else if (w_complete && !r_mem_we) begin
      r_load_data <= w_ld_data;
    end
  end

  assign mem.mem_valid = (r_state == ST_BUSY);
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  assign load_data = r_load_data;
  assign dbg_state = r_state;

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus
// hand-written wait-state and reset-during-access sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        stall;
  logic        misaligned;
  logic        load_valid;
  logic [31:0] load_data;
  lsu_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;

  lsu_if #(.BUS_WIDTH(32)) mem_bus ();

  load_store_unit #(.BUS_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .stall        (stall),
    .misaligned   (misaligned),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .dbg_state    (dbg_state),
    .mem          (mem_bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[$];

  // driver: present one request and walk it through to retirement
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    alu_result   = v.addr;
    store_data   = v.sdata;
    mem_bus.mem_rdata = v.rdata;
    mem_bus.mem_ready = 1'b0;
    #1;
    check({tag, ".misaligned"}, misaligned, v.exp_mis);
    if (v.exp_mis) begin
      check({tag, ".stall"}, stall, 0);
      check({tag, ".mem_valid"}, mem_bus.mem_valid, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check({tag, ".mem_valid_next"}, mem_bus.mem_valid, 0);
      check({tag, ".state_idle"}, dbg_state, ST_IDLE);
      req_valid = 1'b0;
    end else begin
      check({tag, ".stall_accept"}, stall, 1);
      check({tag, ".mem_valid_accept"}, mem_bus.mem_valid, 0);
      @(posedge clk);
      @(negedge clk);
      mem_bus.mem_ready = 1'b1;
      #1;
      check({tag, ".mem_valid"}, mem_bus.mem_valid, 1);
      check({tag, ".mem_addr"}, mem_bus.mem_addr, v.exp_addr);
      check({tag, ".mem_be"}, mem_bus.mem_be, v.exp_be);
      check({tag, ".mem_we"}, mem_bus.mem_we, v.we);
      check({tag, ".stall_busy"}, stall, 1);
      if (v.we) check({tag, ".mem_wdata"}, mem_bus.mem_wdata, v.exp_wdata);
      @(posedge clk);
      @(negedge clk);
      mem_bus.mem_ready = 1'b0;
      #1;
      check({tag, ".stall_done"}, stall, 0);
      check({tag, ".mem_valid_done"}, mem_bus.mem_valid, 0);
      check({tag, ".load_valid"}, load_valid, !v.we);
      if (!v.we) check({tag, ".load_data"}, load_data, v.exp_ld);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check({tag, ".load_valid_after"}, load_valid, 0);
      check({tag, ".stall_after"}, stall, 0);
    end
  endtask

  initial begin
    int stall_cycles;

    // we size uns addr sdata rdata | mis addr be wdata load
    vecs.push_back('{1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b1, SIZE_BYTE, 1'b0, 32'h103, 32'h000000A5, 32'h0, 1'b0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{1'b1, SIZE_HALF, 1'b0, 32'h202, 32'h1234BEEF, 32'h0, 1'b0, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0});
    vecs.push_back('{1'b1, SIZE_BYTE, 1'b0, 32'h201, 32'hFFFFFF3C, 32'h0, 1'b0, 32'h200, 4'b0010, 32'h3C3C3C3C, 32'h0});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b0, 32'h102, 32'h0, 32'h12F45678, 1'b0, 32'h100, 4'b0100, 32'h0, 32'hFFFFFFF4});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b1, 32'h102, 32'h0, 32'h12F45678, 1'b0, 32'h100, 4'b0100, 32'h0, 32'h000000F4});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b0, 32'h102, 32'h0, 32'h12F45678, 1'b0, 32'h100, 4'b1100, 32'h0, 32'h000012F4});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'h12F45678, 1'b0, 32'h100, 4'b1111, 32'h0, 32'h12F45678});
    vecs.push_back('{1'b0, SIZE_BYTE, 1'b0, 32'h101, 32'h0, 32'h12F45678, 1'b0, 32'h100, 4'b0010, 32'h0, 32'h00000056});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b0, 32'h100, 32'h0, 32'hABCD8001, 1'b0, 32'h100, 4'b0011, 32'h0, 32'hFFFF8001});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b1, 32'h102, 32'h0, 32'hABCD8001, 1'b0, 32'h100, 4'b1100, 32'h0, 32'h0000ABCD});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b1, 32'h104, 32'h0, 32'h80000001, 1'b0, 32'h104, 4'b1111, 32'h0, 32'h80000001});
    vecs.push_back('{1'b0, SIZE_WORD, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, SIZE_HALF, 1'b0, 32'h203, 32'h1234, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, SIZE_HALF, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, SIZE_WORD, 1'b0, 32'h102, 32'h55, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0});

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = SIZE_BYTE;
    req_unsigned = 1'b0;
    alu_result   = '0;
    store_data   = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.mem_valid", mem_bus.mem_valid, 0);
    check("rst.mem_we", mem_bus.mem_we, 0);
    check("rst.mem_be", mem_bus.mem_be, 0);
    check("rst.mem_addr", mem_bus.mem_addr, 0);
    check("rst.mem_wdata", mem_bus.mem_wdata, 0);
    check("rst.load_data", load_data, 0);
    check("rst.load_valid", load_valid, 0);
    check("rst.stall", stall, 0);
    check("rst.misaligned", misaligned, 0);
    check("rst.state", dbg_state, ST_IDLE);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // wait states: mem_ready low for 5 cycles (accept cycle + 4 BUSY cycles),
    // so stall covers 6 cycles and completion lands on the first ready cycle
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = SIZE_WORD;
    req_unsigned = 1'b0;
    alu_result   = 32'h300;
    store_data   = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0BADBAD0;
    #1;
    stall_cycles = stall ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      mem_bus.mem_ready = (i == 4);
      mem_bus.mem_rdata = (i == 4) ? 32'hCAFEF00D : 32'h0BADBAD0 + i;
      #1;
      if (stall) stall_cycles++;
      check($sformatf("ws%0d.mem_valid", i), mem_bus.mem_valid, 1);
      check($sformatf("ws%0d.mem_addr", i), mem_bus.mem_addr, 32'h300);
      check($sformatf("ws%0d.mem_be", i), mem_bus.mem_be, 4'b1111);
      check($sformatf("ws%0d.mem_we", i), mem_bus.mem_we, 0);
      check($sformatf("ws%0d.load_valid", i), load_valid, 0);
    end
    @(posedge clk);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    #1;
    if (stall) stall_cycles++;
    check("ws.stall_cycles", stall_cycles, 6);
    check("ws.load_valid", load_valid, 1);
    check("ws.load_data", load_data, 32'hCAFEF00D);
    check("ws.mem_valid_done", mem_bus.mem_valid, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("ws.load_valid_after", load_valid, 0);

    // reset while BUSY: access is abandoned and a late ready is ignored
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = SIZE_HALF;
    alu_result   = 32'h102;
    mem_bus.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rb.mem_valid_busy", mem_bus.mem_valid, 1);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hFFFF0000;
    #1;
    check("rb.mem_valid", mem_bus.mem_valid, 0);
    check("rb.stall", stall, 0);
    check("rb.load_data", load_data, 0);
    check("rb.state", dbg_state, ST_IDLE);
    @(posedge clk);
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    #1;
    check("rb.load_valid", load_valid, 0);
    check("rb.load_data_after", load_data, 0);
    check("rb.mem_valid_after", mem_bus.mem_valid, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_load_store_unit
